// File: rtl/x_driver_pkg.sv
// rtl/x_driver_pkg.sv - shared types and constants for the tester-to-23K640 command driver
package x_driver_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    RETURN  = 2'd3
  } state_e;

  // Bit positions inside a tester byte
  localparam int BIT_LOAD  = 0;
  localparam int BIT_SHIFT = 1;
  localparam int BIT_EXEC  = 2;

  // Command word width: {mask, rd_n_wr, addr, wdata}
  function automatic int cmd_w(input int channels, input int addr_w);
    return channels + 1 + addr_w + 8;
  endfunction

endpackage

// File: rtl/x_adv_gen.sv
// rtl/x_adv_gen.sv - programmable-period advance strobe generator
module x_adv_gen (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic [6:0] top_i,
  output logic       advance_o
);

  logic [6:0] top_q;
  logic [6:0] cnt_q;
  logic       hit_w;

  assign hit_w = (cnt_q == top_q);

  // The strobe is forced low while reset is held so it reads idle during reset
  assign advance_o = hit_w & rst_n_i;

  // Period register and free-running counter; a smaller new period wraps through 127
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) begin
        top_q <= top_i;
      end
      cnt_q <= hit_w ? 7'd0 : cnt_q + 7'd1;
    end
  end

endmodule

// File: rtl/x_driver_mc.sv
// rtl/x_driver_mc.sv - multi-channel tester-to-23K640 command driver top
module x_driver_mc
  import x_driver_pkg::*;
#(
  parameter int P_CHANNELS = 16,
  parameter int P_ADDR_W   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_test_valid,
  input  logic [7:0]              i_test_data,
  input  logic                    i_test_ready,
  output logic                    o_test_valid,
  output logic [7:0]              o_test_data,
  output logic                    o_busy,
  output logic                    o_advance,
  output logic                    o_rd_n_wr,
  output logic [P_ADDR_W-1:0]     o_addr,
  output logic [7:0]              o_wdata,
  output logic [P_CHANNELS-1:0]   o_valid,
  input  logic [P_CHANNELS-1:0]   i_accept,
  input  logic [P_CHANNELS-1:0]   i_ready,
  input  logic [P_CHANNELS*8-1:0] i_rdata
);

  localparam int CMD_W = cmd_w(P_CHANNELS, P_ADDR_W);
  localparam int IDX_W = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;

  logic load_w, shift_w, exec_w;
  logic unused_w;

  logic [CMD_W-1:0]      cmd_q;
  logic [P_CHANNELS-1:0] cmd_mask_w;
  logic                  cmd_rd_w;
  logic [P_ADDR_W-1:0]   cmd_addr_w;
  logic [7:0]            cmd_wdata_w;

  state_e                state_q, state_d;
  logic [P_CHANNELS-1:0] mask_q, valid_q, pend_q, hit_w;
  logic                  rd_q;
  logic [P_ADDR_W-1:0]   addr_q;
  logic [7:0]            wdata_q;
  logic [7:0]            rbuf_q [P_CHANNELS];
  logic [IDX_W-1:0]      idx_q;
  logic                  tvalid_q;
  logic [7:0]            tdata_q;

  logic                  first_found, next_found;
  logic [IDX_W-1:0]      first_idx, next_idx;

  assign load_w   = i_test_valid & i_test_data[BIT_LOAD];
  assign shift_w  = i_test_valid & i_test_data[BIT_SHIFT];
  assign exec_w   = i_test_valid & i_test_data[BIT_EXEC];
  assign unused_w = i_test_data[3];

  assign cmd_mask_w  = cmd_q[CMD_W-1 -: P_CHANNELS];
  assign cmd_rd_w    = cmd_q[8+P_ADDR_W];
  assign cmd_addr_w  = cmd_q[8 +: P_ADDR_W];
  assign cmd_wdata_w = cmd_q[7:0];

  assign hit_w = i_ready & pend_q;

  assign o_valid      = valid_q;
  assign o_rd_n_wr    = rd_q;
  assign o_addr       = addr_q;
  assign o_wdata      = wdata_q;
  assign o_test_valid = tvalid_q;
  assign o_test_data  = tdata_q;

  x_adv_gen u_adv (
    .clk_i     (i_clk),
    .rst_n_i   (i_rst_n),
    .load_i    (load_w),
    .top_i     (i_test_data[7:1]),
    .advance_o (o_advance)
  );

  // Lowest set mask bit, and lowest set mask bit above the current return index
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int c = P_CHANNELS - 1; c >= 0; c--) begin
      if (mask_q[c]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(c);
        if (c > int'(idx_q)) begin
          next_found = 1'b1;
          next_idx   = IDX_W'(c);
        end
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (exec_w) state_d = ISSUE;
      end
      ISSUE: begin
        if ((valid_q & ~i_accept) == '0) begin
          state_d = (rd_q && (mask_q != '0)) ? COLLECT : IDLE;
        end
      end
      COLLECT: begin
        if (pend_q == '0) state_d = first_found ? RETURN : IDLE;
      end
      RETURN: begin
        if (i_test_ready && !next_found) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_busy = (state_q != IDLE);
  end

  // Command shifting, held request, read capture and return-byte registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cmd_q    <= '0;
      mask_q   <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      valid_q  <= '0;
      pend_q   <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      for (int c = 0; c < P_CHANNELS; c++) rbuf_q[c] <= '0;
    end else begin
      if (shift_w) begin
        cmd_q <= {cmd_q[CMD_W-5:0], i_test_data[7:4]};
      end
      if (state_q == IDLE && exec_w) begin
        mask_q  <= cmd_mask_w;
        rd_q    <= cmd_rd_w;
        addr_q  <= cmd_addr_w;
        wdata_q <= cmd_wdata_w;
        valid_q <= cmd_mask_w;
        pend_q  <= cmd_mask_w & {P_CHANNELS{cmd_rd_w}};
      end
      if (state_q == ISSUE) begin
        valid_q <= valid_q & ~i_accept;
      end
      if (state_q == ISSUE || state_q == COLLECT) begin
        pend_q <= pend_q & ~hit_w;
        for (int c = 0; c < P_CHANNELS; c++) begin
          if (hit_w[c]) rbuf_q[c] <= i_rdata[8*c +: 8];
        end
      end
      if (state_q == COLLECT && pend_q == '0 && first_found) begin
        idx_q    <= first_idx;
        tvalid_q <= 1'b1;
        tdata_q  <= rbuf_q[first_idx];
      end
      if (state_q == RETURN && i_test_ready) begin
        if (next_found) begin
          idx_q   <= next_idx;
          tdata_q <= rbuf_q[next_idx];
        end else begin
          tvalid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/x_driver_mc.md
Name: x_driver_mc

Overview:
Parametrised multi-channel tester-to-23K640 command driver. Tester bytes load an advance-strobe period and shift in a command word (channel mask, rd_n_wr, address, write data), then execute it. The block holds per-channel valid until accept and collects read data on ready. It streams read bytes back to the tester with backpressure. It sits between the tester UART bridge and P_CHANNELS sram channel controllers.

Parameters:
P_CHANNELS, 16, number of 23K640 channels (1..16)
P_ADDR_W, 16, address width driven to every channel

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous reset, active low
i_test_valid  in  1  tester byte strobe
i_test_data  in  8  tester byte; bit0 load period, bit1 shift nibble, bit2 execute
i_test_ready  in  1  tester accepts o_test_data this cycle
o_test_valid  out  1  return byte valid
o_test_data  out  8  return byte (read data)
o_busy  out  1  FSM not in IDLE
o_advance  out  1  advance strobe, one cycle per period
o_rd_n_wr  out  1  held operation type
o_addr  out  P_ADDR_W  held address
o_wdata  out  8  held write data
o_valid  out  P_CHANNELS  per-channel request valid
i_accept  in  P_CHANNELS  per-channel request accepted
i_ready  in  P_CHANNELS  per-channel read data valid pulse
i_rdata  in  P_CHANNELS*8  flattened read data, channel c at [8c+7:8c]

Behaviour:
- Reset (i_rst_n=0 at posedge): all registers 0. o_valid=0, o_test_valid=0, o_test_data=0, o_busy=0, o_advance=0, o_rd_n_wr=0, o_addr=0, o_wdata=0. The FSM enters IDLE. Reset mid-operation abandons all pending work, with no return bytes.
- CMD_W = P_CHANNELS+1+P_ADDR_W+8. cmd_q is CMD_W bits, packed {mask, rd_n_wr, addr, wdata}.
- Shift: when i_test_valid & bit1, cmd_q <= {cmd_q[CMD_W-5:0], i_test_data[7:4]}. Shift is allowed in any state; it does not affect held outputs.
- Period: when i_test_valid & bit0, top_q <= i_test_data[7:1].
- Advance counter: 7-bit cnt_q. If cnt_q==top_q then cnt_q<=0, else cnt_q<=cnt_q+1. o_advance = (cnt_q==top_q), combinational.
  - top_q=0 gives o_advance constantly high.
  - Loading a top_q smaller than the current cnt_q makes the counter wrap through 127 to 0 before the next strobe.
- Execute: when i_test_valid & bit2 in IDLE, capture mask, rd_n_wr, addr and wdata into held registers. Set valid_q=mask and pend_q=mask&{P_CHANNELS{rd_n_wr}}. Next state is ISSUE.
  - Execute outside IDLE is ignored, with no state change.
  - One byte carrying several of bits 0/1/2 applies them all in the same cycle. Execute uses cmd_q before that cycle's shift.
- FSM states: IDLE, ISSUE, COLLECT, RETURN.
- ISSUE:
  - valid_q <= valid_q & ~i_accept each cycle.
  - i_accept bits for channels with valid_q=0 are ignored.
  - Leave ISSUE once valid_q is 0 (or becomes 0 this cycle): go to COLLECT if rd_n_wr, else IDLE.
  - mask=0 goes from ISSUE to IDLE after one cycle, with no return bytes.
- Read capture (ISSUE or COLLECT):
  - When i_ready[c] & pend_q[c]: rbuf[c] <= i_rdata[c], pend_q[c] <= 0.
  - A ready arriving in the same cycle as its accept is captured.
  - A ready for a non-pending channel is ignored.
- COLLECT: when pend_q==0, set idx to the lowest set mask bit and go to RETURN. No timeout.
- RETURN:
  - o_test_valid=1, o_test_data=rbuf[idx]. Both are registered and stable until i_test_ready.
  - On handshake, idx advances to the next set mask bit in ascending order. After the last one, drop o_test_valid and go to IDLE.
  - Exactly popcount(mask) bytes are returned, one per handshake.
- o_rd_n_wr, o_addr and o_wdata hold their captured values until the next execute.

Decomposition:
- Package x_driver_pkg: state enum (IDLE, ISSUE, COLLECT, RETURN), tester bit-position constants (LOAD=0, SHIFT=1, EXEC=2), function cmd_w(channels, addr_w).
- Sub-module x_adv_gen: 7-bit period register plus counter producing o_advance.
- Priority "next set bit" search stays inline.

Test Plan:
- Reset, then load byte 0x07 (top=3): o_advance pulses every 4 cycles. Reload 0x01 (top=0): o_advance stuck high.
- P_CHANNELS=16 write: shift nibbles for mask=0x0005, rd_n_wr=0, addr=0x1234, wdata=0xA5, then execute 0x04. Expected: o_valid=0x0005, o_addr=0x1234, o_wdata=0xA5. Accept ch2 then ch0 on separate cycles: valid drops per bit, then IDLE. No return bytes.
- Read with mask=0x8002, addr=0x0010:
  - Accept both.
  - i_ready ch15 with rdata 0x3C, then ch1 with rdata 0xC3.
  - Expected: return bytes 0xC3 then 0x3C. i_test_ready is held low for 5 cycles and o_test_data must stay 0xC3 throughout.
- Execute while busy: second execute ignored, held addr unchanged. Execute with mask=0: back to IDLE in 2 cycles, o_test_valid never asserted.
- Simultaneous events: accept and ready for ch1 in the same cycle during a read are both honoured. Spurious ready on a non-masked channel is ignored.
- i_rst_n low during RETURN: o_test_valid=0, o_valid=0, o_busy=0 the next cycle.
